stream_word_unpacker: RTL and testbench

- Splits wide stream words into narrower output beats, least-significant slice first; valid/ready handshakes on both sides.
- Does the opposite job to the word-packing path, which uses get_word_count_for_size to pack narrow units into wide words.
- Sits between wide datapath buffers and narrow egress/serial interfaces.
- Honours a per-word unit count so a partial final word emits only its valid slices.

---
 rtl/math_pkg.sv | 28 ++
 rtl/stream_word_unpacker.sv | 145 ++++++++++++++
 tb/tb_stream_word_unpacker.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/math_pkg.sv
// Shared width helpers and small enums used across the stream datapath blocks.
package math_pkg;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Bits needed to index `depth` entries, never less than one.
  function automatic int vect_range(input int depth);
    int bits;
    bits = clog2(depth);
    return (bits < 1) ? 1 : bits;
  endfunction

  typedef enum logic [0:0] {
    UNPK_IDLE,
    UNPK_DRAIN
  } unpk_state_t;

endpackage

// File: rtl/stream_word_unpacker.sv
// Splits wide stream words into narrow beats, least-significant slice first,
// honouring a per-word slice count and tracking beats per frame.
module stream_word_unpacker
  import math_pkg::*;
#(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 8,
  localparam int RATIO    = IN_WIDTH / OUT_WIDTH,
  localparam int CNT_W    = clog2(RATIO + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [CNT_W-1:0]     in_count,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [15:0]          frame_beats
);

  localparam int IDX_W = vect_range(RATIO);

  if (IN_WIDTH % OUT_WIDTH != 0) begin : g_width_check
    $error("IN_WIDTH must be an integer multiple of OUT_WIDTH");
  end

  // A count of 0 means a full word; anything above RATIO is clamped.
  function automatic logic [IDX_W-1:0] eff_last_idx(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] eff;
    eff = (cnt == '0 || cnt > CNT_W'(RATIO)) ? CNT_W'(RATIO) : cnt;
    return IDX_W'(eff - 1'b1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  unpk_state_t          state_p1;
  unpk_state_t          state_d;
  logic [IN_WIDTH-1:0]  word_p1;
  logic                 last_p1;
  logic [IDX_W-1:0]     idx_p1;
  logic [IDX_W-1:0]     last_idx_p1;
  logic [15:0]          beats_p1;

  logic                 load;
  logic                 advance;
  logic                 final_slice;
  logic                 beat_hs;

  assign final_slice = (idx_p1 == last_idx_p1);
  assign beat_hs     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= UNPK_IDLE;
    end else begin
      state_p1 <= state_d;
    end
  end

  // The final beat of a word hands in_ready straight through from out_ready,
  // so a waiting word is taken in the same cycle and no bubble appears.
  always_comb begin
    state_d   = state_p1;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    unique case (state_p1)
      UNPK_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = UNPK_DRAIN;
        end
      end
      UNPK_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (final_slice) begin
            in_ready = 1'b1;
            if (in_valid) begin
              load = 1'b1;
            end else begin
              state_d = UNPK_IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: begin
        state_d = UNPK_IDLE;
      end
    endcase
  end

  // ---- stage p1: held word, slice index and per-word slice limit ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_p1     <= '0;
      last_p1     <= 1'b0;
      idx_p1      <= '0;
      last_idx_p1 <= '0;
    end else if (load) begin
      word_p1     <= in_data;
      last_p1     <= in_last;
      idx_p1      <= '0;
      last_idx_p1 <= eff_last_idx(in_count);
    end else if (advance) begin
      idx_p1      <= idx_p1 + 1'b1;
    end
  end

  assign out_data = word_p1[idx_p1 * OUT_WIDTH +: OUT_WIDTH];
  assign out_last = (state_p1 == UNPK_DRAIN) && last_p1 && final_slice;

  // Clearing on the frame's last beat takes priority over counting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_p1 <= '0;
    end else if (beat_hs && out_last) begin
      beats_p1 <= '0;
    end else if (beat_hs) begin
      beats_p1 <= sat_inc16(beats_p1);
    end
  end

  assign frame_beats = beats_p1;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      assert (in_count <= CNT_W'(RATIO))
        else $error("in_count %0d exceeds RATIO %0d; clamped", in_count, RATIO);
    end
  end
`endif

endmodule

// File: tb/tb_stream_word_unpacker.sv
// Directed and randomised-backpressure bench for stream_word_unpacker (32 -> 8).
module tb_stream_word_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_count;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [15:0] frame_beats;

  int checks = 0;
  int errors = 0;
  logic [15:0] fb_exp;

  always #5 clk = ~clk;

  stream_word_unpacker #(
    .IN_WIDTH (32),
    .OUT_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_count   (in_count),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_beats(frame_beats)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0]     data;
    logic [2:0]      count;
    logic            last;
    logic [2:0]      n;
    logic [3:0][7:0] beats;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  // Present one word with out_ready=1 and check every beat it produces.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = v.data;
    in_count  = v.count;
    in_last   = v.last;
    out_ready = 1'b1;
    #1;
    check("vec_accept_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < int'(v.n); k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check("vec_out_valid", out_valid, 1);
      check("vec_out_data", out_data, v.beats[k]);
      check("vec_out_last", out_last, v.last && (k == int'(v.n) - 1));
      check("vec_frame_beats", frame_beats, fb_exp);
      fb_exp = (v.last && (k == int'(v.n) - 1)) ? 16'd0 : fb_exp + 16'd1;
    end
    @(negedge clk);
    #1;
    check("vec_idle_valid", out_valid, 0);
    check("vec_idle_frame_beats", frame_beats, fb_exp);
  endtask

  vec_t  vecs [6];
  beat_t q [$];

  initial begin
    logic [7:0] b2b [8];
    logic [7:0] hold_d;
    logic       hold_l;
    logic       stall;
    logic       accepted;
    int         sent;
    int         eff;
    beat_t      b;

    vecs[0] = '{data: 32'h44332211, count: 3'd4, last: 1'b1, n: 3'd4, beats: {8'h44, 8'h33, 8'h22, 8'h11}};
    vecs[1] = '{data: 32'h00FFEEDD, count: 3'd3, last: 1'b1, n: 3'd3, beats: {8'h00, 8'hFF, 8'hEE, 8'hDD}};
    vecs[2] = '{data: 32'h87654321, count: 3'd0, last: 1'b1, n: 3'd4, beats: {8'h87, 8'h65, 8'h43, 8'h21}};
    vecs[3] = '{data: 32'hCAFEBABE, count: 3'd1, last: 1'b0, n: 3'd1, beats: {8'h00, 8'h00, 8'h00, 8'hBE}};
    vecs[4] = '{data: 32'h1234BEEF, count: 3'd2, last: 1'b1, n: 3'd2, beats: {8'h00, 8'h00, 8'hBE, 8'hEF}};
    vecs[5] = '{data: 32'hA1B2C3D4, count: 3'd4, last: 1'b1, n: 3'd4, beats: {8'hA1, 8'hB2, 8'hC3, 8'hD4}};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_count  = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    fb_exp    = '0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_beats", frame_beats, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
    end

    // Back-to-back words with no bubble between them.
    b2b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 32'hDDCCBBAA;
    in_count  = 3'd4;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    check("b2b_first_accept", in_ready, 1);
    @(negedge clk);
    in_data = 32'h04030201;
    in_last = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 4) in_valid = 1'b0;
      #1;
      check("b2b_out_valid", out_valid, 1);
      check("b2b_out_data", out_data, b2b[i]);
      check("b2b_in_ready", in_ready, (i == 3 || i == 7));
      check("b2b_out_last", out_last, (i == 7));
      check("b2b_frame_beats", frame_beats, i);
    end
    @(negedge clk);
    #1;
    check("b2b_idle_valid", out_valid, 0);
    check("b2b_frame_clear", frame_beats, 0);
    fb_exp = '0;

    // Random backpressure against a slice-queue model.
    sent     = 0;
    stall    = 1'b0;
    accepted = 1'b0;
    hold_d   = '0;
    hold_l   = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      if (accepted) in_valid = 1'b0;
      accepted = 1'b0;
      if (sent == 200 && q.size() == 0) break;
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid && sent < 200 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = $urandom;
        in_count = 3'($urandom_range(0, 4));
        in_last  = 1'($urandom_range(0, 1));
      end
      #1;
      if (stall) begin
        check("rand_stall_valid", out_valid, 1);
        check("rand_stall_data", out_data, hold_d);
        check("rand_stall_last", out_last, hold_l);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand_extra_beat: got beat 0x%0h, expected none", out_data);
        end else begin
          b = q.pop_front();
          check("rand_out_data", out_data, b.d);
          check("rand_out_last", out_last, b.l);
        end
      end
      stall  = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      if (in_valid && in_ready) begin
        eff = (in_count == 3'd0) ? 4 : int'(in_count);
        for (int k = 0; k < eff; k++) begin
          b.d = in_data[8*k +: 8];
          b.l = in_last && (k == eff - 1);
          q.push_back(b);
        end
        sent++;
        accepted = 1'b1;
      end
    end
    in_valid = 1'b0;
    check("rand_words_sent", sent, 200);
    check("rand_queue_empty", q.size(), 0);

    // Asynchronous reset in the middle of a word.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 32'h55667788;
    in_count  = 3'd4;
    in_last   = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("rstmid_beat0", out_data, 8'h88);
    @(negedge clk);
    #1;
    check("rstmid_beat1", out_data, 8'h77);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_frame_beats", frame_beats, 0);
    check("rstmid_in_ready", in_ready, 1);
    check("rstmid_out_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("rstmid_no_emit", out_valid, 0);
    end
    fb_exp = '0;
    run_vec(vecs[5]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
